// File: rtl/full_adder.sv
// One-bit full adder cell.
// Ports: a, b, c_in -> s (sum), c_out (carry).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/full_adder_n_bit.sv
// N-bit ripple-carry adder, combinational results plus a registered copy.
// Ports: clk, rst (sync, high), c_in, a, b -> s, c_out, ovf, s_q, c_out_q, ovf_q.
module full_adder_n_bit #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c_in,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf,
  output logic [N-1:0] s_q,
  output logic         c_out_q,
  output logic         ovf_q
);

  // carry[i] is the carry into bit i; carry[N] leaves the MSB.
  logic [N:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .s     (s[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out = carry[N];
  // Signed overflow: carry into the sign bit differs from carry out.
  assign ovf   = carry[N-1] ^ carry[N];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s_q     <= s;
      c_out_q <= c_out;
      ovf_q   <= ovf;
    end
  end

endmodule

// File: tb/tb_full_adder_n_bit.sv
// Self-checking bench for full_adder_n_bit (N=16 and N=1 builds).
// Registered results go through an expected-value queue.
module tb_full_adder_n_bit;

  logic        clk;
  logic        rst;
  logic        c_in;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] s;
  logic        c_out;
  logic        ovf;
  logic [15:0] s_q;
  logic        c_out_q;
  logic        ovf_q;

  logic        c_in1;
  logic [0:0]  a1;
  logic [0:0]  b1;
  logic [0:0]  s1;
  logic        c_out1;
  logic        ovf1;
  logic [0:0]  s_q1;
  logic        c_out_q1;
  logic        ovf_q1;

  int errors = 0;
  int checks = 0;

  logic [17:0] sb_q[$];

  full_adder_n_bit #(.N(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .c_in    (c_in),
    .a       (a),
    .b       (b),
    .s       (s),
    .c_out   (c_out),
    .ovf     (ovf),
    .s_q     (s_q),
    .c_out_q (c_out_q),
    .ovf_q   (ovf_q)
  );

  full_adder_n_bit #(.N(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .c_in    (c_in1),
    .a       (a1),
    .b       (b1),
    .s       (s1),
    .c_out   (c_out1),
    .ovf     (ovf1),
    .s_q     (s_q1),
    .c_out_q (c_out_q1),
    .ovf_q   (ovf_q1)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Reference model: {ovf, c_out, s}.
  function automatic logic [17:0] model16(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        ci
  );
    logic [16:0] sum;
    logic        v;
    sum = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    v = (x[15] == y[15]) && (sum[15] != x[15]);
    return {v, sum};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, check combinational outputs at once,
  // then compare registered outputs after the next rising edge.
  task automatic step(
    input string       tag,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        ci
  );
    logic [17:0] e;
    logic [17:0] r;
    @(negedge clk);
    a = x;
    b = y;
    c_in = ci;
    e = model16(x, y, ci);
    sb_q.push_back(rst ? 18'd0 : e);
    #1;
    chk({tag, "_comb"}, {14'd0, ovf, c_out, s}, {14'd0, e});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      r = sb_q.pop_front();
      chk({tag, "_reg"}, {14'd0, ovf_q, c_out_q, s_q}, {14'd0, r});
    end
  endtask

  initial begin
    logic [17:0] e;
    logic [1:0]  e1;
    logic [2:0]  v;
    rst = 1'b1;
    a = '0;
    b = '0;
    c_in = 1'b0;
    a1 = '0;
    b1 = '0;
    c_in1 = 1'b0;

    @(posedge clk);
    #1;
    chk("reset_state", {14'd0, ovf_q, c_out_q, s_q}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step("t1_ffff_0001", 16'hFFFF, 16'h0001, 1'b0);
    chk("t1_s", {16'd0, s}, 32'h0000);
    chk("t1_cout_ovf", {30'd0, c_out, ovf}, 32'd2);

    step("t2_ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1);
    chk("t2_s", {16'd0, s}, 32'hFFFF);
    chk("t2_cout_ovf", {30'd0, c_out, ovf}, 32'd2);

    step("t3_7fff_0001", 16'h7FFF, 16'h0001, 1'b0);
    chk("t3_s", {16'd0, s}, 32'h8000);
    chk("t3_cout_ovf", {30'd0, c_out, ovf}, 32'd1);

    step("neg_ovf", 16'h8000, 16'h8000, 1'b0);
    step("zero", 16'h0000, 16'h0000, 1'b0);
    step("mixed", 16'hA5A5, 16'h5A5A, 1'b1);

    @(negedge clk);
    rst = 1'b1;
    step("t5_rst_e1", 16'h1234, 16'h1111, 1'b1);
    chk("t5_s_e1", {16'd0, s}, 32'h2346);
    step("t5_rst_e2", 16'h1234, 16'h1111, 1'b1);
    chk("t5_s_e2", {16'd0, s}, 32'h2346);
    @(negedge clk);
    rst = 1'b0;
    step("t5_release", 16'h1234, 16'h1111, 1'b1);
    chk("t5_sq", {16'd0, s_q}, 32'h2346);

    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      a1 = v[2:2];
      b1 = v[1:1];
      c_in1 = v[0];
      #1;
      e1 = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      chk($sformatf("t6_n1_sum_%0d", i), {30'd0, c_out1, s1}, {30'd0, e1});
      chk($sformatf("t6_n1_ovf_%0d", i), {31'd0, ovf1},
          {31'd0, v[0] ^ e1[1]});
    end

    for (int i = 0; i < 100000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c_in = 1'($urandom);
      #1;
      e = model16(a, b, c_in);
      chk("t4_rand", {14'd0, ovf, c_out, s}, {14'd0, e});
      #9;
    end

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
